// File: rtl/jtbubl_prog_if.sv
// Write-side bus from the download adapter towards the SDRAM controller
// write port and the video PROM load port.
interface jtbubl_prog_if;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prom_we;
  logic        sdram_ack;

  modport master (
    output prog_addr,
    output prog_data,
    output prog_mask,
    output prog_we,
    output prom_we,
    input  sdram_ack
  );

  modport slave (
    input  prog_addr,
    input  prog_data,
    input  prog_mask,
    input  prog_we,
    input  prom_we,
    output sdram_ack
  );
endinterface

// File: rtl/jtbubl_prog.sv
// ROM download adapter: queues ioctl bytes in a small FIFO and turns each one
// into either a held, byte-masked SDRAM write or a single-cycle PROM strobe.
module jtbubl_prog #(
  parameter logic [24:0] PROM_START = 25'hC_0000,
  parameter int          FIFO_AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 downloading,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_data,
  input  logic                 ioctl_wr,
  jtbubl_prog_if.master        prog,
  output logic                 dwnld_busy,
  output logic                 ovf
);

  localparam int DEPTH = 2**FIFO_AW;

  typedef struct packed {
    logic        prom;
    logic [24:0] addr;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic {IDLE, WAIT} state_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             full, empty, push, pop, drop;
  logic             dl_q;
  logic [24:0]      prom_off;
  logic             unused_off_hi;

  state_t           state, state_nx;
  logic [21:0]      addr_nx;
  logic [7:0]       data_nx;
  logic [1:0]       mask_nx;
  logic             we_nx, prom_we_nx;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign head  = mem[rd_ptr[FIFO_AW-1:0]];

  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands
  assign push = ioctl_wr && (!full || pop);
  assign drop = ioctl_wr && full && !pop;

  assign prom_off      = head.addr - PROM_START;
  assign unused_off_hi = ^prom_off[24:22];

  assign dwnld_busy = downloading | ~empty | prog.prog_we;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[FIFO_AW-1:0]] <= {ioctl_addr >= PROM_START, ioctl_addr, ioctl_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A fresh download session clears the sticky overflow unless it overflows again at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_q <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (downloading && !dl_q) ovf <= drop;
      else                      ovf <= ovf | drop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      prog.prog_addr <= '0;
      prog.prog_data <= '0;
      prog.prog_mask <= 2'b11;
      prog.prog_we   <= 1'b0;
      prog.prom_we   <= 1'b0;
    end else begin
      state          <= state_nx;
      prog.prog_addr <= addr_nx;
      prog.prog_data <= data_nx;
      prog.prog_mask <= mask_nx;
      prog.prog_we   <= we_nx;
      prog.prom_we   <= prom_we_nx;
    end
  end

  // SDRAM entries stay at the head until acknowledged; PROM entries pop immediately
  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    addr_nx    = prog.prog_addr;
    data_nx    = prog.prog_data;
    mask_nx    = prog.prog_mask;
    we_nx      = prog.prog_we;
    prom_we_nx = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          data_nx = head.data;
          if (head.prom) begin
            addr_nx    = prom_off[21:0];
            prom_we_nx = 1'b1;
            pop        = 1'b1;
          end else begin
            addr_nx  = head.addr[22:1];
            mask_nx  = head.addr[0] ? 2'b01 : 2'b10;
            we_nx    = 1'b1;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (prog.sdram_ack) begin
          we_nx    = 1'b0;
          mask_nx  = 2'b11;
          pop      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtbubl_prog.sv
// Scoreboard bench for jtbubl_prog: stimulus queues hand-computed writes,
// a monitor pops them as prog_we/prom_we appear on the bus.
module tb_jtbubl_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic        dwnld_busy, ovf;

  jtbubl_prog_if bus();

  jtbubl_prog dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog        (bus),
    .dwnld_busy  (dwnld_busy),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          prom;
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
    int          hold;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  int   ack_delay = 1;
  bit   ack_en = 1'b1;
  int   ack_count = 0;
  int   wait_cnt = 0;

  exp_t mon_cur;
  bit   mon_have = 1'b0;
  int   mon_len = 0;
  logic mon_we_q = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one ioctl write cycle starting at posedge+1, records its expected bus transaction
  task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d, input bit expect_push,
                               input bit e_prom, input logic [21:0] e_addr,
                               input logic [1:0] e_mask, input int e_hold);
    exp_t e;
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    if (expect_push) begin
      e.prom = e_prom;
      e.addr = e_addr;
      e.data = d;
      e.mask = e_mask;
      e.hold = e_hold;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (dwnld_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, dwnld_busy}, 0);
    @(posedge clk); #1;
  endtask

  // SDRAM model: acknowledges ack_delay cycles after prog_we rises
  initial begin
    bus.sdram_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus.sdram_ack = 1'b0;
        wait_cnt = 0;
      end else if (bus.prog_we && !bus.sdram_ack && ack_en) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          bus.sdram_ack = 1'b1;
          wait_cnt = 0;
          ack_count++;
        end
      end else begin
        bus.sdram_ack = 1'b0;
        if (!bus.prog_we) wait_cnt = 0;
      end
    end
  end

  // Monitor: pops one expectation per prom_we cycle or per prog_we rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_have = 1'b0;
        mon_we_q = 1'b0;
        mon_len  = 0;
        continue;
      end
      if (bus.prom_we) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_prom_we", 1, 0);
        end else begin
          mon_cur = exp_q.pop_front();
          checkOutput("prom_kind", 1, {31'd0, mon_cur.prom});
          checkOutput("prom_addr", {10'd0, bus.prog_addr}, {10'd0, mon_cur.addr});
          checkOutput("prom_data", {24'd0, bus.prog_data}, {24'd0, mon_cur.data});
          checkOutput("prom_no_prog_we", {31'd0, bus.prog_we}, 0);
        end
      end
      if (bus.prog_we && !mon_we_q) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_prog_we", 1, 0);
          mon_have = 1'b0;
        end else begin
          mon_cur  = exp_q.pop_front();
          mon_have = 1'b1;
          mon_len  = 1;
          checkOutput("sdram_kind", 0, {31'd0, mon_cur.prom});
          checkOutput("sdram_addr", {10'd0, bus.prog_addr}, {10'd0, mon_cur.addr});
          checkOutput("sdram_data", {24'd0, bus.prog_data}, {24'd0, mon_cur.data});
          checkOutput("sdram_mask", {30'd0, bus.prog_mask}, {30'd0, mon_cur.mask});
        end
      end else if (bus.prog_we && mon_we_q) begin
        mon_len++;
        if (mon_have) begin
          checkOutput("hold_addr", {10'd0, bus.prog_addr}, {10'd0, mon_cur.addr});
          checkOutput("hold_data", {24'd0, bus.prog_data}, {24'd0, mon_cur.data});
          checkOutput("hold_mask", {30'd0, bus.prog_mask}, {30'd0, mon_cur.mask});
        end
      end else if (!bus.prog_we && mon_we_q) begin
        if (mon_have && mon_cur.hold != 0)
          checkOutput("prog_we_len", mon_len, mon_cur.hold);
        checkOutput("mask_after_ack", {30'd0, bus.prog_mask}, 32'd3);
        mon_have = 1'b0;
      end
      mon_we_q = bus.prog_we;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int n;
    int highs;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_prog_we",   {31'd0, bus.prog_we}, 0);
    checkOutput("rst_prom_we",   {31'd0, bus.prom_we}, 0);
    checkOutput("rst_prog_addr", {10'd0, bus.prog_addr}, 0);
    checkOutput("rst_prog_data", {24'd0, bus.prog_data}, 0);
    checkOutput("rst_prog_mask", {30'd0, bus.prog_mask}, 32'd3);
    checkOutput("rst_busy",      {31'd0, dwnld_busy}, 0);
    checkOutput("rst_ovf",       {31'd0, ovf}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single SDRAM byte, ack after 3 cycles");
    downloading = 1'b1;
    ack_delay = 3;
    applyStimulus(25'h0, 8'hA5, 1, 0, 22'h0, 2'b10, 3);
    checkOutput("latency_edge_n", {31'd0, bus.prog_we}, 0);
    @(posedge clk); #1;
    checkOutput("latency_edge_n1", {31'd0, bus.prog_we}, 1);
    downloading = 1'b0;
    drain("drain_single");

    $display("[TB] odd addresses, high byte mask, push order");
    downloading = 1'b1;
    ack_delay = 2;
    applyStimulus(25'h00001, 8'h11, 1, 0, 22'h0,     2'b01, 2);
    applyStimulus(25'h28001, 8'h22, 1, 0, 22'h14000, 2'b01, 2);
    downloading = 1'b0;
    drain("drain_odd");

    $display("[TB] PROM writes and boundary");
    downloading = 1'b1;
    applyStimulus(25'hC0012,   8'h07, 1, 1, 22'h12,     2'b11, 0);
    applyStimulus(25'hBFFFF,   8'h5A, 1, 0, 22'h5FFFF,  2'b01, 2);
    applyStimulus(25'hC0000,   8'h01, 1, 1, 22'h0,      2'b11, 0);
    applyStimulus(25'hC0001,   8'h02, 1, 1, 22'h1,      2'b11, 0);
    applyStimulus(25'h1FFFFFF, 8'h3C, 1, 1, 22'h33FFFF, 2'b11, 0);
    downloading = 1'b0;
    drain("drain_prom");

    $display("[TB] overflow with ack withheld");
    downloading = 1'b1;
    ack_en = 1'b0;
    applyStimulus(25'h100, 8'hB0, 1, 0, 22'h80, 2'b10, 0);
    applyStimulus(25'h101, 8'hB1, 1, 0, 22'h80, 2'b01, 0);
    applyStimulus(25'h102, 8'hB2, 1, 0, 22'h81, 2'b10, 0);
    applyStimulus(25'h103, 8'hB3, 1, 0, 22'h81, 2'b01, 0);
    applyStimulus(25'h104, 8'hB4, 0, 0, 22'h0,  2'b11, 0);
    @(negedge clk);
    checkOutput("ovf_set",  {31'd0, ovf}, 1);
    checkOutput("ovf_busy", {31'd0, dwnld_busy}, 1);
    @(posedge clk); #1;
    downloading = 1'b0;
    ack_delay = 1;
    ack_en = 1'b1;
    drain("drain_ovf");
    checkOutput("ovf_sticky", {31'd0, ovf}, 1);
    downloading = 1'b1;
    @(posedge clk); #1;
    checkOutput("ovf_cleared", {31'd0, ovf}, 0);

    $display("[TB] downloading drops with queued bytes");
    ack_en = 1'b0;
    applyStimulus(25'h200, 8'h31, 1, 0, 22'h100, 2'b10, 0);
    applyStimulus(25'h202, 8'h32, 1, 0, 22'h101, 2'b10, 0);
    applyStimulus(25'h205, 8'h33, 1, 0, 22'h102, 2'b01, 0);
    downloading = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("busy_while_queued", {31'd0, dwnld_busy}, 1);
    end
    @(posedge clk); #1;
    base = ack_count;
    ack_delay = 2;
    ack_en = 1'b1;
    n = 0;
    while (!(bus.sdram_ack && ack_count == base + 3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("third_ack_seen", ack_count - base, 3);
    checkOutput("busy_at_third_ack", {31'd0, dwnld_busy}, 1);
    @(negedge clk);
    checkOutput("busy_after_third_ack", {31'd0, dwnld_busy}, 0);
    @(posedge clk); #1;

    $display("[TB] reset during WAIT");
    downloading = 1'b1;
    ack_en = 1'b0;
    applyStimulus(25'h300, 8'h41, 1, 0, 22'h180, 2'b10, 0);
    applyStimulus(25'h301, 8'h42, 1, 0, 22'h180, 2'b01, 0);
    applyStimulus(25'h302, 8'h43, 1, 0, 22'h181, 2'b10, 0);
    applyStimulus(25'h303, 8'h44, 1, 0, 22'h181, 2'b01, 0);
    applyStimulus(25'h304, 8'h45, 0, 0, 22'h0,   2'b11, 0);
    @(negedge clk);
    checkOutput("pre_rst_ovf",     {31'd0, ovf}, 1);
    checkOutput("pre_rst_prog_we", {31'd0, bus.prog_we}, 1);
    downloading = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_prog_we", {31'd0, bus.prog_we}, 0);
    checkOutput("async_rst_ovf",     {31'd0, ovf}, 0);
    checkOutput("async_rst_busy",    {31'd0, dwnld_busy}, 0);
    checkOutput("async_rst_mask",    {30'd0, bus.prog_mask}, 32'd3);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ack_en = 1'b1;
    highs = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.prog_we || bus.prom_we) highs++;
    end
    checkOutput("no_write_after_rst", highs, 0);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
